// File: rtl/dbus_pkg.sv
// Shared types and helpers for the uncached data-bus responder.
package dbus_pkg;

    localparam int DBUS_AW = 32;
    localparam int DBUS_DW = 32;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } dbus_size_t;

    typedef struct packed {
        logic               write;
        dbus_size_t         size;
        logic [DBUS_AW-1:0] addr;
        logic [DBUS_DW-1:0] wdata;
        logic               kill;
    } dbus_entry_t;

    // Byte enables for a lane-aligned access; the unused size code is treated as a word.
    function automatic logic [3:0] gen_wstrb(input dbus_size_t size, input logic [1:0] addr_lo);
        logic [3:0] strb;
        case (size)
            BYTE:    strb = 4'b0001 << addr_lo;
            HALF:    strb = 4'b0011 << {addr_lo[1], 1'b0};
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/dbus_req_fifo.sv
// In-order request buffer with three pointers: head (oldest awaiting completion),
// issue (next to send downstream) and tail (next free slot), plus per-entry kill bits.
module dbus_req_fifo
    import dbus_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_flush,
    input  logic        i_push,
    input  dbus_entry_t i_push_entry,
    input  logic        i_issue_ack,
    input  logic        i_retire,
    output logic        o_full,
    output logic        o_issue_valid,
    output logic        o_outstanding,
    output dbus_entry_t o_issue_entry,
    output dbus_entry_t o_head_entry
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    logic [PW-1:0] r_head;
    logic [PW-1:0] r_issue;
    logic [PW-1:0] r_tail;
    logic          r_flush_d;
    dbus_entry_t   r_mem [DEPTH];

    logic [PW-1:0]    w_used;
    logic [PW-1:0]    w_unissued_cnt;
    logic [DEPTH-1:0] w_live;
    logic [DEPTH-1:0] w_unissued;
    logic             w_issue_pend;
    logic             w_skip;
    logic [IW-1:0]    w_wr_idx;

    assign w_used         = r_tail - r_head;
    assign w_unissued_cnt = r_tail - r_issue;
    assign w_issue_pend   = (r_issue != r_tail);
    assign o_full         = (w_used == PW'(DEPTH));
    assign o_outstanding  = (r_head != r_issue);
    assign o_issue_entry  = r_mem[r_issue[IW-1:0]];
    assign o_head_entry   = r_mem[r_head[IW-1:0]];
    assign o_issue_valid  = w_issue_pend & ~o_issue_entry.kill;

    // The cycle after a flush, tail is pulled back to issue, so a new push lands at issue.
    assign w_wr_idx = r_flush_d ? r_issue[IW-1:0] : r_tail[IW-1:0];

    // Killed unissued entries are stepped over; not during the tail pull-back cycle,
    // where they are dropped wholesale instead.
    assign w_skip = w_issue_pend & o_issue_entry.kill & ~r_flush_d;

    // Slot membership in the live window [head, tail) and the unissued window [issue, tail).
    always_comb begin
        w_live     = '0;
        w_unissued = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_live[i]     = {1'b0, IW'(i) - r_head[IW-1:0]}  < w_used;
            w_unissued[i] = {1'b0, IW'(i) - r_issue[IW-1:0]} < w_unissued_cnt;
        end
    end

    // Pointer, kill-bit and storage update.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_head    <= '0;
            r_issue   <= '0;
            r_tail    <= '0;
            r_flush_d <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_flush_d <= i_flush;
            for (int i = 0; i < DEPTH; i++) begin
                if (i_flush && w_live[i]) begin
                    r_mem[i].kill <= 1'b1;
                end
                if (r_flush_d && w_unissued[i]) begin
                    r_mem[i].kill <= 1'b0;
                end
            end
            if (i_push) begin
                r_mem[w_wr_idx] <= i_push_entry;
            end
            if (r_flush_d) begin
                r_tail <= r_issue + PW'(i_push);
            end else begin
                r_tail <= r_tail + PW'(i_push);
            end
            if (i_issue_ack || w_skip) begin
                r_issue <= r_issue + 1'b1;
            end
            if (i_retire) begin
                r_head <= r_head + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dbus_uncached_responder.sv
// Uncached data-bus responder: buffers commit-stage requests, replays them in order
// on a single-outstanding-address memory port and returns in-order responses.
module dbus_uncached_responder
    import dbus_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          flush,
    input  logic          req_valid,
    input  logic          req_write,
    input  logic [1:0]    req_size,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          req_addr_ok,
    output logic          resp_data_ok,
    output logic [DW-1:0] resp_rdata,
    output logic          mem_req,
    output logic          mem_wr,
    output logic [1:0]    mem_size,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_wstrb,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_addr_ok,
    input  logic          mem_data_ok,
    input  logic [DW-1:0] mem_rdata
);

    logic          r_alive;
    logic          r_resp_valid;
    logic [DW-1:0] r_resp_rdata;

    logic          w_full;
    logic          w_push;
    logic          w_issue_valid;
    logic          w_outstanding;
    logic          w_retire;
    logic          w_respond;
    dbus_entry_t   w_push_entry;
    dbus_entry_t   w_issue;
    dbus_entry_t   w_head;

    // Request acceptance; r_alive keeps addr_ok low while in reset.
    assign req_addr_ok = r_alive & ~w_full & ~flush;
    assign w_push      = req_valid & req_addr_ok;

    always_comb begin
        w_push_entry       = '0;
        w_push_entry.write = req_write;
        w_push_entry.size  = dbus_size_t'(req_size);
        w_push_entry.addr  = DBUS_AW'(req_addr);
        w_push_entry.wdata = DBUS_DW'(req_wdata);
        w_push_entry.kill  = 1'b0;
    end

    dbus_req_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk           (clk),
        .resetn        (resetn),
        .i_flush       (flush),
        .i_push        (w_push),
        .i_push_entry  (w_push_entry),
        .i_issue_ack   (mem_req & mem_addr_ok),
        .i_retire      (w_retire),
        .o_full        (w_full),
        .o_issue_valid (w_issue_valid),
        .o_outstanding (w_outstanding),
        .o_issue_entry (w_issue),
        .o_head_entry  (w_head)
    );

    // No new downstream request is launched in a flush cycle, since its entry is being killed.
    assign mem_req   = w_issue_valid & ~flush;
    assign mem_wr    = mem_req & w_issue.write;
    assign mem_size  = mem_req ? w_issue.size : 2'b00;
    assign mem_addr  = mem_req ? AW'(w_issue.addr) : '0;
    assign mem_wstrb = mem_req ? gen_wstrb(w_issue.size, w_issue.addr[1:0]) : 4'b0000;
    assign mem_wdata = mem_req ? DW'(w_issue.wdata) : '0;

    // A completion with nothing issued is ignored; a flush in the same cycle kills the retiring entry.
    assign w_retire  = mem_data_ok & w_outstanding;
    assign w_respond = w_retire & ~w_head.kill & ~flush;

    assign resp_data_ok = r_resp_valid;
    assign resp_rdata   = r_resp_rdata;

    // Response register: one-cycle pulse, load data captured, stores return zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_alive      <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            r_alive      <= 1'b1;
            r_resp_valid <= w_respond;
            if (w_respond) begin
                r_resp_rdata <= w_head.write ? '0 : mem_rdata;
            end
        end
    end

    a_data_ok_outstanding: assert property (@(posedge clk) disable iff (!resetn)
        mem_data_ok |-> w_outstanding);

endmodule

// File: tb/tb_dbus_uncached_responder.sv
module tb_dbus_uncached_responder;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_addr_ok;
    logic        resp_data_ok;
    logic [31:0] resp_rdata;
    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  strb;
        logic [31:0] resp;
    } vec_t;

    vec_t vecs [8];
    vec_t v_extra;

    always #5 clk = ~clk;

    dbus_uncached_responder dut (
        .clk          (clk),
        .resetn       (resetn),
        .flush        (flush),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_addr_ok  (req_addr_ok),
        .resp_data_ok (resp_data_ok),
        .resp_rdata   (resp_rdata),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_addr     (mem_addr),
        .mem_wstrb    (mem_wstrb),
        .mem_wdata    (mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata)
    );

    always @(posedge clk) begin
        if (resetn && req_valid) begin
            assert (!((req_size == 2'd1 && req_addr[0]) || (req_size == 2'd2 && req_addr[1:0] != 2'b00)))
                else $error("misaligned request driven");
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drive_req(input logic wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        req_valid = 1'b1;
        req_write = wr;
        req_size  = sz;
        req_addr  = a;
        req_wdata = wd;
    endtask

    // Full single transaction: accept, issue, completion after 3 cycles, one-cycle response.
    task automatic run_vec(input vec_t v);
        drive_req(v.wr, v.size, v.addr, v.wdata);
        sample();
        check("accept", {31'b0, req_addr_ok}, 32'd1);
        tick();
        req_valid = 1'b0;
        sample();
        check("mem_req", {31'b0, mem_req}, 32'd1);
        check("mem_wr", {31'b0, mem_wr}, {31'b0, v.wr});
        check("mem_size", {30'b0, mem_size}, {30'b0, v.size});
        check("mem_addr", mem_addr, v.addr);
        check("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, v.strb});
        check("mem_wdata", mem_wdata, v.wdata);
        mem_addr_ok = 1'b1;
        tick();
        mem_addr_ok = 1'b0;
        sample();
        check("mem_req_after_issue", {31'b0, mem_req}, 32'd0);
        tick();
        tick();
        mem_data_ok = 1'b1;
        mem_rdata   = v.rdata;
        tick();
        mem_data_ok = 1'b0;
        mem_rdata   = 32'h0;
        sample();
        check("resp_pulse", {31'b0, resp_data_ok}, 32'd1);
        check("resp_rdata", resp_rdata, v.resp);
        tick();
        sample();
        check("resp_single", {31'b0, resp_data_ok}, 32'd0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //          wr    size   addr           wdata          rdata          strb     resp
        vecs[0] = '{1'b0, 2'd2, 32'h1fc00010, 32'h00000000, 32'hdeadbeef, 4'b1111, 32'hdeadbeef};
        vecs[1] = '{1'b1, 2'd0, 32'h1fc00003, 32'h11000000, 32'hcafef00d, 4'b1000, 32'h00000000};
        vecs[2] = '{1'b0, 2'd0, 32'h00000001, 32'h00000000, 32'h0000ab00, 4'b0010, 32'h0000ab00};
        vecs[3] = '{1'b0, 2'd1, 32'h00000002, 32'h00000000, 32'h12340000, 4'b1100, 32'h12340000};
        vecs[4] = '{1'b1, 2'd1, 32'h80000000, 32'h00005566, 32'hffffffff, 4'b0011, 32'h00000000};
        vecs[5] = '{1'b0, 2'd0, 32'h00000000, 32'h00000000, 32'h000000ee, 4'b0001, 32'h000000ee};
        vecs[6] = '{1'b1, 2'd0, 32'h00000002, 32'h00770000, 32'h01020304, 4'b0100, 32'h00000000};
        vecs[7] = '{1'b1, 2'd2, 32'h00000ffc, 32'ha5a5a5a5, 32'h99999999, 4'b1111, 32'h00000000};

        resetn = 1'b0; flush = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_addr = 32'h0; req_wdata = 32'h0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;

        // Reset values, then a mid-cycle reset with a request pending downstream.
        tick(); tick();
        resetn = 1'b1;
        tick(); tick();
        sample();
        check("rst_addr_ok", {31'b0, req_addr_ok}, 32'd1);
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_resp", {31'b0, resp_data_ok}, 32'd0);
        tick();
        drive_req(1'b1, 2'd0, 32'h00000003, 32'h11000000);
        tick();
        req_valid = 1'b0;
        sample();
        check("pre_rst_mem_req", {31'b0, mem_req}, 32'd1);
        #2 resetn = 1'b0;
        #1;
        check("midrst_addr_ok", {31'b0, req_addr_ok}, 32'd0);
        check("midrst_resp", {31'b0, resp_data_ok}, 32'd0);
        check("midrst_rdata", resp_rdata, 32'd0);
        check("midrst_mem_req", {31'b0, mem_req}, 32'd0);
        check("midrst_mem_wr", {31'b0, mem_wr}, 32'd0);
        check("midrst_wstrb", {28'b0, mem_wstrb}, 32'd0);
        check("midrst_size", {30'b0, mem_size}, 32'd0);
        check("midrst_addr", mem_addr, 32'd0);
        check("midrst_wdata", mem_wdata, 32'd0);
        tick();
        resetn = 1'b1;
        tick(); tick();
        sample();
        check("post_rst_addr_ok", {31'b0, req_addr_ok}, 32'd1);
        check("post_rst_mem_req", {31'b0, mem_req}, 32'd0);
        tick();

        // Table-driven single transactions.
        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i]);
        end

        // Fill to DEPTH with downstream stalled; 5th request waits; in-order drain.
        for (int t = 0; t < 4; t++) begin
            drive_req(1'b0, 2'd2, 32'h100 + 32'(4 * t), 32'h0);
            sample();
            check("fill_accept", {31'b0, req_addr_ok}, 32'd1);
            tick();
        end
        drive_req(1'b0, 2'd2, 32'h110, 32'h0);
        sample();
        check("fill_full", {31'b0, req_addr_ok}, 32'd0);
        tick();
        for (int k = 0; k < 5; k++) begin
            sample();
            check("fill_issue", {31'b0, mem_req}, 32'd1);
            check("fill_order_addr", mem_addr, 32'h100 + 32'(4 * k));
            mem_addr_ok = 1'b1;
            tick();
            mem_addr_ok = 1'b0;
            mem_data_ok = 1'b1;
            mem_rdata   = 32'ha0 + 32'(k);
            tick();
            mem_data_ok = 1'b0;
            sample();
            check("fill_resp", {31'b0, resp_data_ok}, 32'd1);
            check("fill_order_data", resp_rdata, 32'ha0 + 32'(k));
            if (k == 0) begin
                check("fill_reopen", {31'b0, req_addr_ok}, 32'd1);
            end
            tick();
            if (k == 0) begin
                req_valid = 1'b0;
            end
        end

        // Flush with 3 entries, 1 issued.
        for (int t = 0; t < 3; t++) begin
            drive_req(1'b0, 2'd2, 32'h200 + 32'(4 * t), 32'h0);
            tick();
        end
        req_valid = 1'b0;
        sample();
        check("fl_issue_addr", mem_addr, 32'h200);
        mem_addr_ok = 1'b1;
        tick();
        mem_addr_ok = 1'b0;
        flush = 1'b1;
        drive_req(1'b0, 2'd2, 32'h300, 32'h0);
        sample();
        check("fl_no_accept", {31'b0, req_addr_ok}, 32'd0);
        check("fl_no_req", {31'b0, mem_req}, 32'd0);
        tick();
        flush = 1'b0;
        req_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            sample();
            check("fl_dropped", {31'b0, mem_req}, 32'd0);
            tick();
        end
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h55555555;
        tick();
        mem_data_ok = 1'b0;
        sample();
        check("fl_killed_resp", {31'b0, resp_data_ok}, 32'd0);
        tick();
        v_extra = '{1'b0, 2'd2, 32'h00000300, 32'h0, 32'h0badf00d, 4'b1111, 32'h0badf00d};
        run_vec(v_extra);

        // Completion coincident with flush.
        drive_req(1'b0, 2'd2, 32'h400, 32'h0);
        tick();
        drive_req(1'b0, 2'd2, 32'h404, 32'h0);
        tick();
        req_valid   = 1'b0;
        mem_addr_ok = 1'b1;
        tick(); tick();
        mem_addr_ok = 1'b0;
        sample();
        check("cn_both_issued", {31'b0, mem_req}, 32'd0);
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h77777777;
        flush       = 1'b1;
        tick();
        mem_data_ok = 1'b0;
        flush       = 1'b0;
        sample();
        check("cn_coincident", {31'b0, resp_data_ok}, 32'd0);
        tick();
        mem_data_ok = 1'b1;
        tick();
        mem_data_ok = 1'b0;
        sample();
        check("cn_second_killed", {31'b0, resp_data_ok}, 32'd0);
        tick();
        v_extra = '{1'b0, 2'd2, 32'h00000408, 32'h0, 32'h12345678, 4'b1111, 32'h12345678};
        run_vec(v_extra);
        for (int t = 0; t < 4; t++) begin
            drive_req(1'b0, 2'd2, 32'h500 + 32'(4 * t), 32'h0);
            sample();
            check("cn_depth_accept", {31'b0, req_addr_ok}, 32'd1);
            tick();
        end
        drive_req(1'b0, 2'd2, 32'h510, 32'h0);
        sample();
        check("cn_depth_full", {31'b0, req_addr_ok}, 32'd0);
        tick();
        req_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dbus_uncached_responder.md
Name: dbus_uncached_responder

Overview:
- Memory-side responder for the pipeline's uncached data-bus request channel.
- Accepts byte, halfword and word load/store requests from the commit stage and buffers them in an in-order FIFO.
- Replays each request onto a single-outstanding-address, in-order SRAM-like memory port, then returns data_ok and read data to the commit stage in request order.
- Sits between the datapath's uncached request/response pair and the memory bridge.

Parameters:
- DEPTH, 4, request FIFO entries; a power of two and at least 2.
- AW, 32, address width.
- DW, 32, data width; fixed at 32 for this design.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous reset, active low
- flush  in  1  pipeline flush; kills every buffered request whose response has not yet returned
- req_valid  in  1  request present
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word
- req_addr  in  AW  physical address
- req_wdata  in  DW  store data, already lane-aligned
- req_addr_ok  out  1  request accepted this cycle
- resp_data_ok  out  1  response for the oldest live request
- resp_rdata  out  DW  load data, raw 32-bit word
- mem_req  out  1  downstream request valid
- mem_wr  out  1  downstream write
- mem_size  out  2  copy of req_size
- mem_addr  out  AW  downstream address
- mem_wstrb  out  4  byte enables
- mem_wdata  out  DW  downstream store data
- mem_addr_ok  in  1  downstream address accepted
- mem_data_ok  in  1  downstream completion, in order
- mem_rdata  in  DW  downstream read data

Behaviour:
- Reset (resetn low, asynchronous):
  - FIFO empty; all pointers and counters at 0.
  - req_addr_ok = 0, resp_data_ok = 0, resp_rdata = 0, mem_req = 0, mem_wr = 0, mem_wstrb = 0.
  - mem_size, mem_addr and mem_wdata are 0.
  - Reset mid-transaction discards everything; any late mem_data_ok for pre-reset requests is the memory bridge's responsibility, since it is reset together with this block.
- FIFO pointers (log2(DEPTH)+1 bits, wrap-around via the MSB):
  - tail: next write slot.
  - issue: next entry to send downstream.
  - head: oldest entry awaiting mem_data_ok.
  - Invariant: head <= issue <= tail, modulo wrap.
  - full = (tail - head) == DEPTH.
- Accept:
  - req_addr_ok = ~full & ~flush (combinational).
  - An entry is written when req_valid & req_addr_ok.
  - No bubble: accepting at full is impossible; accepting and retiring the head in the same cycle is allowed.
- Issue:
  - mem_req = (issue != tail) & ~kill[issue].
  - The downstream fields come from entry[issue] and are held stable until mem_addr_ok.
  - issue advances on mem_req & mem_addr_ok.
  - A killed entry that is still unissued is skipped: issue advances without asserting mem_req.
- Strobe generation from size and addr[1:0]:
  - byte: 4'b0001 << a.
  - half: 4'b0011 << {a[1], 1'b0}.
  - word: 4'b1111.
- Alignment:
  - Misaligned requests (half with addr[0] set, or word with addr[1:0] nonzero) never arrive; the bench asserts this.
  - Exception detection is upstream.
- Complete:
  - On mem_data_ok the entry at head retires and head advances.
  - If the entry is not killed, then on the next cycle resp_data_ok = 1 for exactly one cycle and resp_rdata = mem_rdata registered (loads; stores return 0).
  - A killed entry retires silently.
- Flush:
  - Sets kill on every entry between head and tail.
  - No accept in the flush cycle.
  - A resp_data_ok already registered in the flush cycle is still driven.
  - Killed but issued entries still consume their mem_data_ok.
  - Killed unissued entries are dropped: tail resets to issue on the next cycle, after the kill bits are cleared for reuse.
- Simultaneous mem_data_ok and flush in the same cycle: the retiring entry counts as killed, so no resp_data_ok is produced.
- mem_data_ok with head == issue is a protocol error; it is flagged by an assertion and ignored.

Decomposition:
- Shared package dbus_pkg holds:
  - the dbus_size_t enum (BYTE, HALF, WORD);
  - the dbus_entry_t struct (write, size, addr, wdata, kill);
  - the strobe function gen_wstrb(size, addr_lo).
- One sub-module, dbus_req_fifo: storage plus the head/issue/tail pointers and kill bits.
- The top level holds the handshake logic and the response register.

Test Plan:
- Reset values: resetn = 0 in mid-cycle -> all outputs 0 immediately; after release, req_addr_ok = 1 and mem_req = 0.
- Single load: load word at 0x1fc00010, mem_addr_ok the same cycle, mem_data_ok after 3 cycles with rdata 0xdeadbeef -> mem_wstrb = 4'b1111; resp_data_ok pulses one cycle later with 0xdeadbeef.
- Byte store: store byte at 0x...03 with wdata 0x11000000 -> mem_wstrb = 4'b1000, mem_wr = 1; resp_data_ok pulses once with rdata 0.
- Fill: DEPTH = 4, mem_addr_ok held low, 5 back-to-back requests -> req_addr_ok drops after the 4th; after 4 completions, order is preserved (tags 0..3, then 4).
- Flush: 3 entries, 1 issued, flush asserted -> no req_addr_ok that cycle; the issued entry's mem_data_ok yields no resp_data_ok; the 2 unissued entries never raise mem_req; the next request issues normally.
- Corner: mem_data_ok coincident with flush -> no response pulse, and head advances by exactly 1.
